hex_display_sequencer: RTL and testbench

Selects which 16-bit debug quantity drives the four seven-segment digits on the board: data bus, address bus, program counter, instruction halves, or r0..r7. It sits between the core's debug outputs and the board's HEX0..HEX3 pins, alongside the GPIO board driver. Two push-buttons control it. Each button is synchronised and debounced and produces single-cycle edge pulses. Three modes are supported: manual stepping, automatic rotation, and frozen snapshot.

---
 rtl/hex_display_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hex_display_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_sequencer.sv
// -----------------------------------------------------------------------------
// hex_display_sequencer
//
// Chooses which 16-bit debug quantity drives the four seven-segment digits.
// Two raw push-buttons are synchronised, debounced and edge-detected.
//   btn_next steps the source.
//   btn_mode cycles MANUAL -> AUTO -> HOLD -> MANUAL.
// In AUTO the source also advances every AUTO_PERIOD cycles. HOLD freezes the
// displayed value and ignores btn_next.
//
// Ports
//   clock      system clock, all state on the rising edge
//   reset      synchronous, active-high
//   btn_next   raw button (asynchronous), active-high
//   btn_mode   raw button (asynchronous), active-high
//   sources    NUM_SRC x 16-bit sources, source k at [16k+15:16k]
//   hex0..hex3 active-high segments (bit0=a .. bit6=g), hex0 = nibble [3:0]
//   sel        current source index
//   mode       0=MANUAL, 1=AUTO, 2=HOLD
// -----------------------------------------------------------------------------
module hex_display_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int NUM_SRC         = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  btn_next,
    input  logic                  btn_mode,
    input  logic [16*NUM_SRC-1:0] sources,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [3:0]            sel,
    output logic [1:0]            mode
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_BAD    = 2'd3
    } mode_e;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AT_W-1:0] AT_LAST  = AT_W'(AUTO_PERIOD - 1);
    localparam logic [3:0]      SEL_LAST = 4'(NUM_SRC - 1);

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Button vectors: index 0 is btn_next, index 1 is btn_mode.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      pulse;
    logic            next_p;
    logic            mode_p;

    mode_e           mode_q, mode_d;
    logic [3:0]      sel_q, sel_d;
    logic [AT_W-1:0] timer_q, timer_d;
    logic            auto_tick;
    logic            advance;
    logic [15:0]     src_cur;
    logic [15:0]     disp_q, disp_d;
    logic [3:0][6:0] hex_q, hex_d;

    // -------------------------------------------------------------------------
    // Synchroniser and debouncer. The counter measures how long the
    // synchronised level has disagreed with the debounced level. Any agreement
    // restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sync1_d   = {btn_mode, btn_next};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level, exactly one cycle wide.
    assign pulse  = db_q & ~db_prev_q;
    assign next_p = pulse[0];
    assign mode_p = pulse[1];

    // -------------------------------------------------------------------------
    // Mode FSM. The unused encoding falls back to MANUAL.
    // -------------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_MANUAL: if (mode_p) mode_d = MODE_AUTO;
            MODE_AUTO:   if (mode_p) mode_d = MODE_HOLD;
            MODE_HOLD:   if (mode_p) mode_d = MODE_MANUAL;
            default:     mode_d = MODE_MANUAL;
        endcase
    end

    // -------------------------------------------------------------------------
    // Source select, auto timer, display register and segment decode.
    // next_p is judged against the mode at the start of the cycle, so a
    // simultaneous mode press still lets the step take effect. Timer expiry
    // and next_p together produce a single step because both feed one OR.
    // -------------------------------------------------------------------------
    always_comb begin
        auto_tick = (mode_q == MODE_AUTO) && (timer_q == AT_LAST);
        advance   = (next_p && (mode_q == MODE_MANUAL || mode_q == MODE_AUTO)) || auto_tick;

        sel_d = sel_q;
        if (advance) begin
            sel_d = (sel_q == SEL_LAST) ? 4'd0 : sel_q + 4'd1;
        end

        timer_d = '0;
        if (mode_q == MODE_AUTO && !next_p && !auto_tick) begin
            timer_d = timer_q + AT_W'(1);
        end

        src_cur = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == 4'(k)) src_cur = sources[16*k +: 16];
        end

        // The last load before HOLD uses the pre-transition mode, so the frozen
        // value is the one captured on the cycle before HOLD is entered.
        disp_d = (mode_q == MODE_HOLD) ? disp_q : src_cur;

        for (int n = 0; n < 4; n++) begin
            hex_d[n] = seg7(disp_q[4*n +: 4]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well as the control
            // state, because the display must show 0000 straight after reset.
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '{default: '0};
            mode_q    <= MODE_MANUAL;
            sel_q     <= '0;
            timer_q   <= '0;
            disp_q    <= '0;
            hex_q     <= {4{7'h3F}};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            disp_q    <= disp_d;
            hex_q     <= hex_d;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign sel  = sel_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for hex_display_sequencer with small parameters (debounce 4, auto 10).
// A behavioural model tracks the expected sel, mode and hex digits. The bench
// compares the DUT against that model on every falling edge. Hand-derived
// literal checks pin the model at the interesting moments.
// -----------------------------------------------------------------------------
module tb_hex_display_sequencer;

    localparam int DB = 4;
    localparam int AP = 10;
    localparam int NS = 13;

    logic            clock    = 1'b0;
    logic            reset    = 1'b1;
    logic            btn_next = 1'b0;
    logic            btn_mode = 1'b0;
    logic [16*NS-1:0] sources;
    logic [6:0]      hex0, hex1, hex2, hex3;
    logic [3:0]      sel;
    logic [1:0]      mode;

    int checks   = 0;
    int failures = 0;

    hex_display_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (AP),
        .NUM_SRC        (NS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_next(btn_next),
        .btn_mode(btn_mode),
        .sources (sources),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .sel     (sel),
        .mode    (mode)
    );

    always #5 clock = ~clock;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model.
    // A button's synchronised view is its raw value from two edges earlier.
    // Its debounced level flips once the last DB synchronised samples all
    // disagree with it. The rising flip acts as a press on the next edge.
    // -------------------------------------------------------------------------
    int         m_sel, m_mode, m_since;
    logic [15:0] m_disp;
    logic [6:0] m_hex [4];
    bit         m_valid = 1'b0;
    bit         pipe [2][2];
    bit         win  [2][DB];
    bit         lvl  [2];
    bit         pend [2];

    always @(posedge clock) begin
        bit raw [2];
        bit synced;
        bit all_diff;
        bit adv;
        raw[0] = btn_next;
        raw[1] = btn_mode;
        if (reset) begin
            m_sel   = 0;
            m_mode  = 0;
            m_since = 0;
            m_disp  = 16'h0000;
            for (int n = 0; n < 4; n++) m_hex[n] = 7'h3F;
            for (int b = 0; b < 2; b++) begin
                pipe[b][0] = 1'b0;
                pipe[b][1] = 1'b0;
                for (int i = 0; i < DB; i++) win[b][i] = 1'b0;
                lvl[b]  = 1'b0;
                pend[b] = 1'b0;
            end
            m_valid = 1'b1;
        end else begin
            // Display pipeline: hex shows the previous value, value follows sel.
            for (int n = 0; n < 4; n++) m_hex[n] = glyph[m_disp[4*n +: 4]];
            if (m_mode != 2) m_disp = sources[16*m_sel +: 16];

            // Stepping: auto expiry after AP cycles in AUTO, or a press outside HOLD.
            adv = 1'b0;
            if (m_mode == 1) begin
                m_since++;
                if (m_since == AP) adv = 1'b1;
            end
            if (pend[0] && m_mode != 2) adv = 1'b1;
            if (adv) begin
                m_sel   = (m_sel + 1) % NS;
                m_since = 0;
            end
            if (pend[1]) m_mode = (m_mode + 1) % 3;
            if (m_mode != 1) m_since = 0;

            for (int b = 0; b < 2; b++) begin
                pend[b]    = 1'b0;
                synced     = pipe[b][0];
                pipe[b][0] = pipe[b][1];
                pipe[b][1] = raw[b];
                for (int i = 0; i < DB - 1; i++) win[b][i] = win[b][i+1];
                win[b][DB-1] = synced;
                all_diff = 1'b1;
                for (int i = 0; i < DB; i++) if (win[b][i] == lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl[b]  = !lvl[b];
                    pend[b] = lvl[b];
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            check("cyc_sel",  32'(sel),  32'(m_sel));
            check("cyc_mode", 32'(mode), 32'(m_mode));
            check("cyc_hex0", 32'(hex0), 32'(m_hex[0]));
            check("cyc_hex1", 32'(hex1), 32'(m_hex[1]));
            check("cyc_hex2", 32'(hex2), 32'(m_hex[2]));
            check("cyc_hex3", 32'(hex3), 32'(m_hex[3]));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int which);
        if (which == 0) btn_next = 1'b1; else btn_mode = 1'b1;
        tick(10);
        if (which == 0) btn_next = 1'b0; else btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic wait_sel_change(input string tag);
        int old;
        int budget;
        old    = m_sel;
        budget = 100;
        while (m_sel == old && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check({tag, "_timeout"}, 32'(m_sel != old), 32'd1);
    endtask

    task automatic wait_sel_is(input int target, input string tag);
        int budget;
        budget = 400;
        while (m_sel == target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        while (m_sel != target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check({tag, "_timeout"}, 32'(m_sel == target), 32'd1);
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
        check({tag, "_hex0"}, 32'(hex0), 32'(e0));
        check({tag, "_hex1"}, 32'(hex1), 32'(e1));
        check({tag, "_hex2"}, 32'(hex2), 32'(e2));
        check({tag, "_hex3"}, 32'(hex3), 32'(e3));
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios followed by randomized activity
    // -------------------------------------------------------------------------
    initial begin
        int s;
        for (int k = 0; k < NS; k++) sources[16*k +: 16] = 16'(k * 16'h1001);

        // Reset
        tick(3);
        reset = 1'b0;
        check("rst_sel",  32'(sel),  32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check_hex("rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        tick(2);
        check("rst_src0_hex0", 32'(hex0), 32'h3F);
        check("rst_src0_hex3", 32'(hex3), 32'h3F);

        // Short glitch is filtered
        btn_next = 1'b1;
        tick(2);
        btn_next = 1'b0;
        tick(10);
        check("glitch_sel", 32'(sel), 32'd0);

        // Long press steps once: source 1 = 1001
        btn_next = 1'b1;
        tick(20);
        btn_next = 1'b0;
        tick(20);
        check("step_sel",  32'(sel),  32'd1);
        check("step_hex0", 32'(hex0), 32'h06);
        check("step_hex3", 32'(hex3), 32'h06);

        // Thirteen presses wrap back to the start
        for (int i = 0; i < 13; i++) press(0);
        check("wrap_sel", 32'(sel), 32'd1);

        // AUTO
        press(1);
        check("auto_mode", 32'(mode), 32'd1);
        wait_sel_change("auto_sync");
        s = m_sel;
        // A press raised now is debounced 7 edges later, mid-period.
        btn_next = 1'b1;
        tick(6);
        check("auto_before_next", 32'(sel), 32'(s));
        tick(1);
        check("auto_next_step",   32'(sel), 32'((s + 1) % NS));
        btn_next = 1'b0;
        tick(9);
        check("auto_period_kept", 32'(sel), 32'((s + 1) % NS));
        tick(1);
        check("auto_period_step", 32'(sel), 32'((s + 2) % NS));

        // HOLD with source 5
        wait_sel_is(5, "hold_sync");
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
        check("hold_mode", 32'(mode), 32'd2);
        check("hold_sel",  32'(sel),  32'd5);
        sources[16*5 +: 16] = 16'hBEEF;
        tick(6);
        check_hex("hold_frozen", 7'h6D, 7'h3F, 7'h3F, 7'h6D);
        press(0);
        check("hold_next_ignored", 32'(sel), 32'd5);
        press(1);
        check("unhold_mode", 32'(mode), 32'd0);
        check_hex("unhold", 7'h71, 7'h79, 7'h79, 7'h7C);

        // Simultaneous presses in MANUAL at sel=2
        for (int i = 0; i < 10; i++) press(0);
        check("sim_pre_sel", 32'(sel), 32'd2);
        btn_next = 1'b1;
        btn_mode = 1'b1;
        tick(10);
        check("sim_sel",  32'(sel),  32'd3);
        check("sim_mode", 32'(mode), 32'd1);
        btn_next = 1'b0;
        btn_mode = 1'b0;
        tick(10);

        // Reset from HOLD, mid-debounce
        press(1);
        check("pre_rst_mode", 32'(mode), 32'd2);
        btn_next = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(3);
        check("hold_rst_mode", 32'(mode), 32'd0);
        check("hold_rst_sel",  32'(sel),  32'd0);
        check_hex("hold_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        reset    = 1'b0;
        btn_next = 1'b0;
        tick(10);
        check("post_rst_sel", 32'(sel), 32'd0);

        // Randomized activity, checked cycle by cycle against the model
        for (int it = 0; it < 250; it++) begin
            int r;
            int k;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset = 1'b1;
                tick($urandom_range(1, 3));
                reset = 1'b0;
            end else if (r < 15) begin
                k = $urandom_range(0, NS - 1);
                sources[16*k +: 16] = 16'($urandom);
                tick(1);
            end else begin
                btn_next = 1'($urandom_range(0, 1));
                btn_mode = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 12));
            end
        end
        btn_next = 1'b0;
        btn_mode = 1'b0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
